ex_muldiv_ctrl: RTL

Iterative RV32M multiply/divide sequencer that sits beside the EX-stage ALU. It accepts a muldiv-class instruction from the ID-EX register and drives a shift-add multiplier or a restoring divider for 32 iterations. While it works it asserts a stall request to the hazard unit. When it finishes it presents the result for the EX-MA register to capture.

---
 rtl/ex_muldiv_ctrl_if.sv | 24 ++
 rtl/ex_muldiv_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_ctrl_if.sv
// rtl/ex_muldiv_ctrl_if.sv - EX-stage muldiv request/response bundle
interface ex_muldiv_ctrl_if #(
  parameter int XLEN = 32
);
  logic            start_i;
  logic [2:0]      func3_i;
  logic [XLEN-1:0] op1_i;
  logic [XLEN-1:0] op2_i;
  logic            squash_i;
  logic            stall_i;
  logic            busy_o;
  logic            done_o;
  logic [XLEN-1:0] result_o;

  modport master (
    output start_i, func3_i, op1_i, op2_i, squash_i, stall_i,
    input  busy_o, done_o, result_o
  );

  modport slave (
    input  start_i, func3_i, op1_i, op2_i, squash_i, stall_i,
    output busy_o, done_o, result_o
  );
endinterface

// File: rtl/ex_muldiv_ctrl.sv
// rtl/ex_muldiv_ctrl.sv - iterative RV32M mul/div sequencer; MULDIV_FAST_MUL_EN selects single-cycle multiply
module ex_muldiv_ctrl #(
  parameter  int XLEN  = 32,
  localparam int CNT_W = $clog2(XLEN) + 1
) (
  input logic             clk,
  input logic             rst_ni,
  ex_muldiv_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;

  localparam int PW = 2 * XLEN + 2;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t            state_q, state_d;
  logic [PW-1:0]     acc_q;
  logic [XLEN:0]     opnd_q;
  logic [2:0]        func_q;
  logic              msb_q, neg_q_q, neg_r_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [XLEN-1:0]   result_q;

  logic              accept, busy, is_div, a_sgn, b_neg, div_sgn;
  logic              op1_neg, op2_neg, div_zero, div_ovf, fast_div, fast_path;
  logic [XLEN:0]     a_ext;
  logic [XLEN-1:0]   op1_mag, op2_mag, fast_res, fix_res;

  assign is_div   = bus.func3_i[2];
  assign a_sgn    = (bus.func3_i == 3'd1) || (bus.func3_i == 3'd2);
  assign a_ext    = {a_sgn & bus.op1_i[XLEN-1], bus.op1_i};
  assign b_neg    = (bus.func3_i == 3'd1) && bus.op2_i[XLEN-1];
  assign div_sgn  = !bus.func3_i[0];
  assign op1_neg  = div_sgn & bus.op1_i[XLEN-1];
  assign op2_neg  = div_sgn & bus.op2_i[XLEN-1];
  assign op1_mag  = op1_neg ? -bus.op1_i : bus.op1_i;
  assign op2_mag  = op2_neg ? -bus.op2_i : bus.op2_i;
  assign div_zero = (bus.op2_i == '0);
  assign div_ovf  = div_sgn && (bus.op1_i == MIN_NEG) && (bus.op2_i == '1);
  assign fast_div = is_div && (div_zero || div_ovf);

`ifdef MULDIV_FAST_MUL_EN
  logic signed [PW-1:0] fast_prod;
  assign fast_prod = $signed(a_ext) * $signed({b_neg, bus.op2_i});
  assign fast_path = fast_div || !is_div;
`else
  assign fast_path = fast_div;
`endif

  always_comb begin
    fast_res = '0;
    if (div_zero)
      fast_res = bus.func3_i[1] ? bus.op1_i : '1;
    else if (div_ovf)
      fast_res = bus.func3_i[1] ? '0 : MIN_NEG;
`ifdef MULDIV_FAST_MUL_EN
    if (!is_div)
      fast_res = (bus.func3_i == 3'd0) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
`endif
  end

  // Multiplier is right-shifting: signed multiplicand added into the top word,
  // low 32 multiplier bits consumed from acc_q[0]; multiplier sign bit fixed up in FIX.
  logic [XLEN+1:0] mul_hi, mul_sum;
  logic [PW-1:0]   mul_next, div_next;
  logic [XLEN:0]   div_shift, div_diff;
  logic            div_ge;
  logic [XLEN-1:0] mul_hi_word, quo, rem;

  assign mul_hi    = acc_q[PW-1:XLEN];
  assign mul_sum   = acc_q[0] ? mul_hi + {opnd_q[XLEN], opnd_q} : mul_hi;
  assign mul_next  = {mul_sum[XLEN+1], mul_sum, acc_q[XLEN-1:1]};

  // Divider keeps remainder in the upper word and dividend/quotient in the lower word.
  assign div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
  assign div_diff  = div_shift - {1'b0, opnd_q[XLEN-1:0]};
  assign div_ge    = !div_diff[XLEN];
  assign div_next  = {2'b00, (div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0]),
                      acc_q[XLEN-2:0], div_ge};

  assign quo         = acc_q[XLEN-1:0];
  assign rem         = acc_q[2*XLEN-1:XLEN];
  assign mul_hi_word = rem - (msb_q ? opnd_q[XLEN-1:0] : '0);

  always_comb begin
    fix_res = '0;
    if (func_q[2]) begin
      if (func_q[1])
        fix_res = neg_r_q ? -rem : rem;
      else
        fix_res = neg_q_q ? -quo : quo;
    end else begin
      fix_res = (func_q == 3'd0) ? quo : mul_hi_word;
    end
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    busy    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start_i && !bus.squash_i) begin
          accept  = 1'b1;
          busy    = 1'b1;
          state_d = fast_path ? DONE : ITER;
        end
      end
      ITER: begin
        if (bus.squash_i) begin
          state_d = IDLE;
        end else begin
          busy = 1'b1;
          if (cnt_q == CNT_W'(1))
            state_d = FIX;
        end
      end
      FIX: begin
        if (bus.squash_i) begin
          state_d = IDLE;
        end else begin
          busy    = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.squash_i || !bus.stall_i)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q    <= '0;
      opnd_q   <= '0;
      func_q   <= '0;
      msb_q    <= 1'b0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            func_q <= bus.func3_i;
            cnt_q  <= CNT_W'(XLEN);
            if (fast_path)
              result_q <= fast_res;
            if (is_div) begin
              acc_q   <= {{(XLEN+2){1'b0}}, op1_mag};
              opnd_q  <= {1'b0, op2_mag};
              msb_q   <= 1'b0;
              neg_q_q <= op1_neg ^ op2_neg;
              neg_r_q <= op1_neg;
            end else begin
              acc_q   <= {{(XLEN+2){1'b0}}, bus.op2_i};
              opnd_q  <= a_ext;
              msb_q   <= b_neg;
              neg_q_q <= 1'b0;
              neg_r_q <= 1'b0;
            end
          end
        end
        ITER: begin
          acc_q <= func_q[2] ? div_next : mul_next;
          cnt_q <= cnt_q - CNT_W'(1);
        end
        FIX: begin
          if (!bus.squash_i)
            result_q <= fix_res;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy_o   = busy;
  assign bus.done_o   = (state_q == DONE);
  assign bus.result_o = result_q;

endmodule
